// File: rtl/rob_if.sv
// Shared configuration types and the rob port bundle: dispatch, writeback,
// operand read and commit, plus flush.
package config_pkg;
    typedef struct packed {
        int unsigned PLEN;
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32'd32, XLEN: 32'd32};

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MUL    = 3'd1,
        FU_DIV    = 3'd2,
        FU_LSU    = 3'd3,
        FU_BRANCH = 3'd4,
        FU_CSR    = 3'd5
    } fu_e;
endpackage

interface rob_if #(
    parameter config_pkg::cfg_t Cfg           = config_pkg::EmptyCfg,
    parameter int unsigned      ROB_DEPTH     = 64,
    parameter int unsigned      ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
    parameter int unsigned      NUM_WB        = 4
);
    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned XLEN = Cfg.XLEN;

    logic [3:0]                              dispatch_valid_i;
    logic [3:0][PLEN-1:0]                    dispatch_pc_i;
    config_pkg::fu_e [3:0]                   dispatch_fu_type_i;
    logic [3:0][4:0]                         dispatch_areg_i;
    logic                                    rob_ready_o;
    logic [ROB_IDX_WIDTH-1:0]                rob_tail_ptr_o;

    logic [NUM_WB-1:0]                       wb_valid_i;
    logic [NUM_WB-1:0][ROB_IDX_WIDTH-1:0]    wb_rob_idx_i;
    logic [NUM_WB-1:0][XLEN-1:0]             wb_data_i;

    logic [7:0][ROB_IDX_WIDTH-1:0]           rd_rob_idx_i;
    logic [7:0]                              rd_ready_o;
    logic [7:0][XLEN-1:0]                    rd_data_o;

    logic [3:0]                              commit_valid_o;
    logic [3:0][4:0]                         commit_areg_o;
    logic [3:0][ROB_IDX_WIDTH-1:0]           commit_rob_idx_o;
    logic [3:0][XLEN-1:0]                    commit_data_o;
    logic [3:0][PLEN-1:0]                    commit_pc_o;

    logic                                    flush_i;

    modport master (
        output dispatch_valid_i, dispatch_pc_i, dispatch_fu_type_i, dispatch_areg_i,
        output wb_valid_i, wb_rob_idx_i, wb_data_i,
        output rd_rob_idx_i, flush_i,
        input  rob_ready_o, rob_tail_ptr_o, rd_ready_o, rd_data_o,
        input  commit_valid_o, commit_areg_o, commit_rob_idx_o, commit_data_o, commit_pc_o
    );

    modport slave (
        input  dispatch_valid_i, dispatch_pc_i, dispatch_fu_type_i, dispatch_areg_i,
        input  wb_valid_i, wb_rob_idx_i, wb_data_i,
        input  rd_rob_idx_i, flush_i,
        output rob_ready_o, rob_tail_ptr_o, rd_ready_o, rd_data_o,
        output commit_valid_o, commit_areg_o, commit_rob_idx_o, commit_data_o, commit_pc_o
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: 4-wide in-order allocate and retire over a circular array,
// with writeback capture and bypassed operand reads.
module rob #(
    parameter config_pkg::cfg_t Cfg           = config_pkg::EmptyCfg,
    parameter int unsigned      ROB_DEPTH     = 64,
    parameter int unsigned      ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
    parameter int unsigned      NUM_WB        = 4
) (
    input logic  clk_i,
    input logic  rst_i,
    rob_if.slave bus
);
    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned XLEN = Cfg.XLEN;
    localparam int unsigned PW   = ROB_IDX_WIDTH + 1;

    typedef logic [ROB_IDX_WIDTH-1:0] idx_t;
    typedef logic [PW-1:0]            ptr_t;

    logic [ROB_DEPTH-1:0] busy_q, busy_d, done_q, done_d, bubble_q, bubble_d;
    logic [PLEN-1:0]      pc_q   [ROB_DEPTH];
    logic [PLEN-1:0]      pc_d   [ROB_DEPTH];
    config_pkg::fu_e      fu_q   [ROB_DEPTH];
    config_pkg::fu_e      fu_d   [ROB_DEPTH];
    logic [4:0]           areg_q [ROB_DEPTH];
    logic [4:0]           areg_d [ROB_DEPTH];
    logic [XLEN-1:0]      data_q [ROB_DEPTH];
    logic [XLEN-1:0]      data_d [ROB_DEPTH];
    ptr_t                 head_q, head_d, tail_q, tail_d, count_q, count_d;

    logic [PW:0]          free_w;
    logic                 ready_w;
    logic                 accept_w;
    logic [2:0]           alloc_n;
    logic [2:0]           ret_n;
    logic [3:0]           retire_w;
    logic                 chain_w;
    idx_t                 cidx [4];
    idx_t                 didx [4];
    logic [NUM_WB-1:0]    wb_take;

    assign free_w   = (PW+1)'(ROB_DEPTH) - {1'b0, count_q};
    assign ready_w  = (free_w >= (PW+1)'(4));
    assign accept_w = ready_w && !bus.flush_i && (|bus.dispatch_valid_i);

    assign bus.rob_ready_o    = ready_w;
    assign bus.rob_tail_ptr_o = tail_q[ROB_IDX_WIDTH-1:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cidx[i] = head_q[ROB_IDX_WIDTH-1:0] + idx_t'(i);
            didx[i] = tail_q[ROB_IDX_WIDTH-1:0] + idx_t'(i);
        end
    end

    // Allocation spans lanes 0..H, so holes below the highest valid lane become bubbles.
    always_comb begin
        alloc_n = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.dispatch_valid_i[i]) alloc_n = 3'(i + 1);
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WB; w++) begin
            wb_take[w] = bus.wb_valid_i[w] && busy_q[bus.wb_rob_idx_i[w]] &&
                         !done_q[bus.wb_rob_idx_i[w]] && !bubble_q[bus.wb_rob_idx_i[w]];
        end
    end

    always_comb begin
        retire_w = '0;
        ret_n    = '0;
        chain_w  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (chain_w && busy_q[cidx[k]] && done_q[cidx[k]] && (ptr_t'(k) < count_q)) begin
                retire_w[k] = 1'b1;
                ret_n       = ret_n + 3'd1;
            end else begin
                chain_w = 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bus.commit_valid_o[k]   = retire_w[k] && !bubble_q[cidx[k]] && !bus.flush_i;
            bus.commit_areg_o[k]    = '0;
            bus.commit_rob_idx_o[k] = '0;
            bus.commit_data_o[k]    = '0;
            bus.commit_pc_o[k]      = '0;
            if (bus.commit_valid_o[k]) begin
                bus.commit_areg_o[k]    = areg_q[cidx[k]];
                bus.commit_rob_idx_o[k] = cidx[k];
                bus.commit_data_o[k]    = data_q[cidx[k]];
                bus.commit_pc_o[k]      = pc_q[cidx[k]];
            end
        end
    end

    // Bypass only when the writeback would actually be captured, so reads match storage.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            bus.rd_ready_o[r] = 1'b0;
            bus.rd_data_o[r]  = '0;
            if (busy_q[bus.rd_rob_idx_i[r]]) begin
                bus.rd_ready_o[r] = done_q[bus.rd_rob_idx_i[r]];
                bus.rd_data_o[r]  = data_q[bus.rd_rob_idx_i[r]];
            end
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_take[w] && (bus.wb_rob_idx_i[w] == bus.rd_rob_idx_i[r])) begin
                    bus.rd_ready_o[r] = 1'b1;
                    bus.rd_data_o[r]  = bus.wb_data_i[w];
                end
            end
        end
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        bubble_d = bubble_q;
        pc_d     = pc_q;
        fu_d     = fu_q;
        areg_d   = areg_q;
        data_d   = data_q;

        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_take[w]) begin
                done_d[bus.wb_rob_idx_i[w]] = 1'b1;
                data_d[bus.wb_rob_idx_i[w]] = bus.wb_data_i[w];
            end
        end

        for (int k = 0; k < 4; k++) begin
            if (retire_w[k]) begin
                busy_d[cidx[k]]   = 1'b0;
                done_d[cidx[k]]   = 1'b0;
                bubble_d[cidx[k]] = 1'b0;
            end
        end

        if (accept_w) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < alloc_n) begin
                    busy_d[didx[i]]   = 1'b1;
                    done_d[didx[i]]   = !bus.dispatch_valid_i[i];
                    bubble_d[didx[i]] = !bus.dispatch_valid_i[i];
                    pc_d[didx[i]]     = bus.dispatch_pc_i[i];
                    fu_d[didx[i]]     = bus.dispatch_fu_type_i[i];
                    areg_d[didx[i]]   = bus.dispatch_areg_i[i];
                    data_d[didx[i]]   = '0;
                end
            end
        end

        head_d  = head_q + ptr_t'(ret_n);
        tail_d  = tail_q + (accept_w ? ptr_t'(alloc_n) : '0);
        count_d = count_q + (accept_w ? ptr_t'(alloc_n) : '0) - ptr_t'(ret_n);

        if (bus.flush_i) begin
            busy_d   = '0;
            done_d   = '0;
            bubble_d = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= '0;
            done_q   <= '0;
            bubble_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                pc_q[e]   <= '0;
                fu_q[e]   <= config_pkg::FU_ALU;
                areg_q[e] <= '0;
                data_q[e] <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            bubble_q <= bubble_d;
            pc_q     <= pc_d;
            fu_q     <= fu_d;
            areg_q   <= areg_d;
            data_q   <= data_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_rob.sv
// Randomized bench for rob: an in-order queue model predicts outputs and the
// retirement stream; a negedge monitor compares them against the DUT.
module tb_rob;
    import config_pkg::*;

    localparam int DEPTH = 64;
    localparam int IW    = 6;
    localparam int NWB   = 4;
    localparam int XL    = 32;
    localparam int PL    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_if #(.Cfg(EmptyCfg), .ROB_DEPTH(DEPTH), .NUM_WB(NWB)) bus ();

    rob #(.Cfg(EmptyCfg), .ROB_DEPTH(DEPTH), .NUM_WB(NWB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          tag;
        logic [PL-1:0] pc;
        logic [4:0]  areg;
        bit          bubble;
        bit          done;
        logic [XL-1:0] data;
    } ment_t;

    typedef struct {
        int          cyc;
        int          lane;
        int          tag;
        logic [4:0]  areg;
        logic [PL-1:0] pc;
        logic [XL-1:0] data;
    } cexp_t;

    typedef struct {
        int                 cyc;
        bit                 chk;
        bit                 zero;
        bit                 ready;
        int                 tail;
        logic [7:0]         rdy;
        logic [7:0][XL-1:0] rdat;
    } oexp_t;

    ment_t mq[$];
    cexp_t cq[$];
    oexp_t oq[$];
    int    tail_m = 0;
    int    cyc    = 0;
    bit    last_r = 1'b1;
    int    checks = 0;
    int    errors = 0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp, int c);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, c, got, exp);
        end
    endfunction

    task automatic clear_inputs();
        bus.dispatch_valid_i = '0;
        bus.dispatch_pc_i    = '0;
        for (int i = 0; i < 4; i++) bus.dispatch_fu_type_i[i] = FU_ALU;
        bus.dispatch_areg_i  = '0;
        bus.wb_valid_i       = '0;
        bus.wb_rob_idx_i     = '0;
        bus.wb_data_i        = '0;
        bus.rd_rob_idx_i     = '0;
        bus.flush_i          = 1'b0;
    endtask

    // Predicts this cycle's outputs from the model, then advances the model at the edge.
    task automatic model_cycle(input bit r);
        oexp_t o;
        cexp_t c;
        int    n;
        int    h;
        cyc++;
        o.cyc   = cyc;
        o.chk   = !r;
        o.zero  = last_r && !r;
        last_r  = r;
        o.ready = (DEPTH - mq.size()) >= 4;
        o.tail  = tail_m;
        n = 0;
        while (n < 4 && n < mq.size() && mq[n].done) n++;
        if (!r && !bus.flush_i) begin
            for (int j = 0; j < n; j++) begin
                if (!mq[j].bubble) begin
                    c.cyc = cyc; c.lane = j; c.tag = mq[j].tag;
                    c.areg = mq[j].areg; c.pc = mq[j].pc; c.data = mq[j].data;
                    cq.push_back(c);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            int t;
            t = int'(bus.rd_rob_idx_i[i]);
            o.rdy[i]  = 1'b0;
            o.rdat[i] = '0;
            foreach (mq[j]) begin
                if (mq[j].tag == t) begin
                    if (mq[j].bubble) begin
                        o.rdy[i] = 1'b1;
                    end else if (mq[j].done) begin
                        o.rdy[i] = 1'b1; o.rdat[i] = mq[j].data;
                    end else begin
                        for (int w = 0; w < NWB; w++) begin
                            if (bus.wb_valid_i[w] && int'(bus.wb_rob_idx_i[w]) == t) begin
                                o.rdy[i] = 1'b1; o.rdat[i] = bus.wb_data_i[w];
                            end
                        end
                    end
                end
            end
        end
        oq.push_back(o);

        @(posedge clk);
        if (r || bus.flush_i) begin
            mq.delete();
            tail_m = 0;
        end else begin
            for (int w = 0; w < NWB; w++) begin
                if (bus.wb_valid_i[w]) begin
                    foreach (mq[j]) begin
                        if (mq[j].tag == int'(bus.wb_rob_idx_i[w]) && !mq[j].bubble && !mq[j].done) begin
                            mq[j].done = 1'b1;
                            mq[j].data = bus.wb_data_i[w];
                        end
                    end
                end
            end
            for (int j = 0; j < n; j++) void'(mq.pop_front());
            if (o.ready && (bus.dispatch_valid_i != 4'b0)) begin
                h = 0;
                for (int i = 0; i < 4; i++) if (bus.dispatch_valid_i[i]) h = i;
                for (int i = 0; i <= h; i++) begin
                    ment_t e;
                    e.tag = tail_m; e.pc = bus.dispatch_pc_i[i]; e.areg = bus.dispatch_areg_i[i];
                    e.bubble = !bus.dispatch_valid_i[i]; e.done = !bus.dispatch_valid_i[i];
                    e.data = '0;
                    mq.push_back(e);
                    tail_m = (tail_m + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    task automatic rand_inputs(input int wb_pct, input int disp_pct, input int fl_pm);
        int cand[$];
        int p;
        clear_inputs();
        if ($urandom_range(0, 99) < disp_pct) bus.dispatch_valid_i = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
            bus.dispatch_pc_i[i]      = $urandom;
            bus.dispatch_areg_i[i]    = 5'($urandom_range(0, 31));
            bus.dispatch_fu_type_i[i] = fu_e'(3'($urandom_range(0, 5)));
        end
        foreach (mq[j]) if (!mq[j].bubble && !mq[j].done) cand.push_back(mq[j].tag);
        for (int w = 0; w < NWB; w++) begin
            bus.wb_data_i[w] = $urandom;
            if (cand.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
                p = $urandom_range(0, cand.size() - 1);
                bus.wb_valid_i[w]   = 1'b1;
                bus.wb_rob_idx_i[w] = IW'(cand[p]);
                cand.delete(p);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                bus.rd_rob_idx_i[i] = IW'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                bus.rd_rob_idx_i[i] = IW'($urandom_range(0, DEPTH - 1));
        end
        if (bus.wb_valid_i[0] && $urandom_range(0, 1) == 1) bus.rd_rob_idx_i[0] = bus.wb_rob_idx_i[0];
        bus.flush_i = ($urandom_range(0, 999) < fl_pm);
    endtask

    task automatic run_phase(input int n, input int wb_pct, input int disp_pct, input int fl_pm);
        for (int c = 0; c < n; c++) begin
            rand_inputs(wb_pct, disp_pct, fl_pm);
            model_cycle(1'b0);
        end
    endtask

    oexp_t mo;
    cexp_t mc;
    int    exp_n;

    always @(negedge clk) begin
        if (oq.size() > 0) begin
            mo = oq.pop_front();
            if (mo.chk) begin
                chk("rob_ready", 64'(bus.rob_ready_o), 64'(mo.ready), mo.cyc);
                chk("tail_ptr", 64'(bus.rob_tail_ptr_o), 64'(mo.tail), mo.cyc);
                for (int i = 0; i < 8; i++) begin
                    chk("rd_ready", 64'(bus.rd_ready_o[i]), 64'(mo.rdy[i]), mo.cyc);
                    chk("rd_data", 64'(bus.rd_data_o[i]), 64'(mo.rdat[i]), mo.cyc);
                end
                exp_n = 0;
                foreach (cq[j]) if (cq[j].cyc == mo.cyc) exp_n++;
                chk("commit_count", 64'($countones(bus.commit_valid_o)), 64'(exp_n), mo.cyc);
                for (int k = 0; k < 4; k++) begin
                    if (bus.commit_valid_o[k] === 1'b1) begin
                        if (cq.size() > 0 && cq[0].cyc == mo.cyc) begin
                            mc = cq.pop_front();
                            chk("commit_lane", 64'(k), 64'(mc.lane), mo.cyc);
                            chk("commit_tag", 64'(bus.commit_rob_idx_o[k]), 64'(mc.tag), mo.cyc);
                            chk("commit_areg", 64'(bus.commit_areg_o[k]), 64'(mc.areg), mo.cyc);
                            chk("commit_pc", 64'(bus.commit_pc_o[k]), 64'(mc.pc), mo.cyc);
                            chk("commit_data", 64'(bus.commit_data_o[k]), 64'(mc.data), mo.cyc);
                        end
                    end else if (mo.zero) begin
                        chk("reset_commit_fields",
                            64'({bus.commit_areg_o[k], bus.commit_rob_idx_o[k]}) |
                            64'(bus.commit_data_o[k]) | 64'(bus.commit_pc_o[k]), 64'(0), mo.cyc);
                    end
                end
            end
            while (cq.size() > 0 && cq[0].cyc <= mo.cyc) void'(cq.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        model_cycle(1'b1);
        model_cycle(1'b1);
        rst = 1'b0;

        clear_inputs();
        bus.dispatch_valid_i = 4'hf;
        for (int i = 0; i < 4; i++) begin
            bus.dispatch_areg_i[i] = 5'(i + 1);
            bus.dispatch_pc_i[i]   = 32'h1000 + 32'(4 * i);
        end
        model_cycle(1'b0);
        clear_inputs();
        for (int w = 0; w < NWB; w++) begin
            bus.wb_valid_i[w]   = 1'b1;
            bus.wb_rob_idx_i[w] = IW'(w);
            bus.wb_data_i[w]    = 32'hA000 + 32'(w);
        end
        bus.rd_rob_idx_i[0] = IW'(2);
        model_cycle(1'b0);
        clear_inputs();
        model_cycle(1'b0);
        model_cycle(1'b0);

        run_phase(800, 60, 70, 10);
        run_phase(200, 5, 90, 0);
        run_phase(200, 90, 10, 0);

        rst = 1'b1;
        rand_inputs(50, 50, 0);
        model_cycle(1'b1);
        rst = 1'b0;

        run_phase(1500, 50, 60, 20);
        run_phase(150, 3, 95, 0);
        run_phase(150, 95, 5, 0);

        clear_inputs();
        model_cycle(1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
